retreo_out_capture: RTL and testbench
=====================================

# retreo_out_capture

Host-side receiver for the ReTReO core's 16-bit output register. It samples `Out_Reg` every clock, detects each new value the core writes, and queues those values in a small first-word-fall-through FIFO. The host drains the FIFO through a valid/ready port. When the FIFO nears full, the block drives the core's `Override_Stall` input for backpressure. It sits between the ReTReO core and the host/bus logic in the top level.

## Interface
- `WIDTH`, 16, data width; must equal the core's `Out_Reg` width.
- `DEPTH`, 8, FIFO entries; must be a power of 2 and at least 4.
- `STALL_MARGIN`, 2, free entries remaining at which the stall asserts; range 1 to DEPTH-1.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `Out_Reg`  in  WIDTH  output register of the core.
- `Override_Stall`  out  1  stall request to the core; registered.
- `Rd_Data`  out  WIDTH  FIFO head word; valid only while `Rd_Valid`=1.
- `Rd_Valid`  out  1  FIFO not empty.
- `Rd_Ready`  in  1  host accepts the head word.
- `Count`  out  $clog2(DEPTH)+1  current occupancy.
- `Overflow`  out  1  sticky flag: a captured word was dropped.
- `Clear_Overflow`  in  1  synchronous clear of `Overflow`.

## Operation
- **Sampling**
  - `last_q` is a WIDTH-bit register, loaded with `Out_Reg` on every edge.
  - `change` = (`Out_Reg` != `last_q`).
  - A repeated write of the same value is not a new word and is not captured.
- **Push**
  - Push is requested when `change`=1.
  - The word written is the current `Out_Reg` value.
- **Pop**
  - Pop occurs when `Rd_Valid` && `Rd_Ready`.
  - `Rd_Data` = mem[rd_ptr] (first-word fall-through; no read latency).
- **Full, no pop**
  - Push while `Count`==DEPTH with no pop in the same cycle: the word is dropped.
  - `Overflow` is set; the FIFO contents and pointers are unchanged.
- **Full, with pop**
  - Push and pop while `Count`==DEPTH: both take effect.
  - `Count` stays at DEPTH; no overflow.
- **Empty**
  - Push while `Count`==0: the word is written.
  - `Rd_Valid` asserts the next cycle. The word does not bypass the FIFO in the same cycle.
  - `Rd_Ready` while empty has no effect.
- **Pointers**
  - Pointers are $clog2(DEPTH) bits and wrap naturally modulo DEPTH.
  - `Count` is tracked separately: +1 on push only, -1 on pop only, unchanged on both or neither.
- **Stall**
  - `Override_Stall` is registered from next_count >= DEPTH-STALL_MARGIN.
  - It deasserts when next_count drops below that threshold.
- **Overflow flag**
  - `Clear_Overflow` clears `Overflow` at the edge.
  - A drop in the same cycle as the clear wins: `Overflow` remains 1.
- **Reset (asynchronous, `rst_n`=0)**
  - `last_q`=0, pointers=0, `Count`=0.
  - `Rd_Valid`=0, `Override_Stall`=0, `Overflow`=0.
  - `Rd_Data` is undefined while `Rd_Valid`=0.
  - FIFO memory is not cleared.
  - Reset mid-operation discards all queued words.
  - Because `last_q`=0 after reset, the first nonzero `Out_Reg` value after reset is captured; a zero value is not.

## Timing
- Capture latency:
  - `Out_Reg` changes before edge k.
  - At edge k the word is written, and `Count`, `Rd_Valid` and `Rd_Data` update after edge k.
  - The host can pop it at edge k+1.
- Pop: the word is consumed at the edge where `Rd_Valid`&&`Rd_Ready`=1; the next head appears after that edge.
- Stall: `Override_Stall` reflects occupancy after edge k in the same cycle as `Count` (zero lag relative to `Count`).
- Core response: the core sees the stall one cycle after the triggering push. `STALL_MARGIN` ≥ 1 absorbs that in-flight write.
- Throughput: one push and one pop per cycle, sustained.
- `Out_Reg` must be stable for setup/hold around `clk`; no internal synchronisation.

## Test plan
- **Reset/first capture**
  - Hold `rst_n`=0; release with `Out_Reg`=16'h0000 for 3 cycles -> `Count`=0, `Rd_Valid`=0.
  - Then `Out_Reg`=16'h0004 -> after next edge `Count`=1, `Rd_Data`=16'h0004.
- **Change detection**
  - `Out_Reg` sequence 16'h0004, 16'h0004, 16'h0010, 16'h0010, 16'h0004 with `Rd_Ready`=0 -> `Count`=3.
  - Popping then yields 16'h0004, 16'h0010, 16'h0004 in order.
- **Fill/stall/overflow** (DEPTH=8, `STALL_MARGIN`=2, `Rd_Ready`=0, `Out_Reg` changing each cycle to 1,2,…,10)
  - `Override_Stall` rises after the 6th capture.
  - `Count` saturates at 8; words 9 and 10 are dropped; `Overflow`=1.
  - Draining yields 1..8.
- **Full simultaneous push/pop**
  - At `Count`=8, `Rd_Ready`=1 and new `Out_Reg`=16'hBEEF -> `Count` stays 8, `Overflow` unchanged.
  - 16'hBEEF is the last word out.
- **Wrap-around**
  - Stream 20 distinct values with `Rd_Ready`=1 every cycle -> all 20 are read in order and `Count` never exceeds 1.
- **Overflow clear vs set, and reset mid-operation**
  - Assert `Clear_Overflow` in the same cycle as a drop -> `Overflow` stays 1; `Clear_Overflow` alone -> 0.
  - Pulse `rst_n`=0 with 5 words queued -> immediately `Count`=0, `Rd_Valid`=0, `Override_Stall`=0.

Source files
------------

// File: rtl/retreo_out_capture.sv
// Purpose: captures each new value written to the core's Out_Reg into a FWFT FIFO for the host.
// Latency: a word written at edge k is visible on Rd_Data/Rd_Valid right after edge k (no bypass).
// Backpressure: Override_Stall asserts once occupancy reaches DEPTH-STALL_MARGIN; words arriving while full are dropped and flagged.
module retreo_out_capture #(
  parameter int WIDTH        = 16,
  parameter int DEPTH        = 8,
  parameter int STALL_MARGIN = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         Out_Reg,
  output logic                     Override_Stall,
  output logic [WIDTH-1:0]         Rd_Data,
  output logic                     Rd_Valid,
  input  logic                     Rd_Ready,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Overflow,
  input  logic                     Clear_Overflow
);

  localparam int AW = $clog2(DEPTH);

  typedef logic [AW:0] cnt_t;

  localparam cnt_t FULL_CNT = cnt_t'(DEPTH);
  localparam cnt_t STALL_TH = cnt_t'(DEPTH - STALL_MARGIN);

  logic [WIDTH-1:0] last_q;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  cnt_t             count_q;
  cnt_t             next_count;
  logic             stall_q;
  logic             ovf_q;

  logic change;
  logic full;
  logic pop;
  logic push;
  logic drop;

  // Change detection against the previous sample; a full FIFO only accepts a
  // word when the head leaves in the same cycle.
  assign change = (Out_Reg != last_q);
  assign full   = (count_q == FULL_CNT);
  assign pop    = Rd_Valid && Rd_Ready;
  assign push   = change && (!full || pop);
  assign drop   = change && full && !pop;

  // Occupancy after this edge; simultaneous push and pop cancel out.
  always_comb begin
    next_count = count_q;
    if (push && !pop) begin
      next_count = count_q + 1'b1;
    end else if (pop && !push) begin
      next_count = count_q - 1'b1;
    end
  end

  // Sample register, pointers, occupancy, stall and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q  <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      stall_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      last_q  <= Out_Reg;
      count_q <= next_count;
      stall_q <= (next_count >= STALL_TH);
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      // A drop in the same cycle as a clear keeps the flag set.
      if (drop) begin
        ovf_q <= 1'b1;
      end else if (Clear_Overflow) begin
        ovf_q <= 1'b0;
      end
    end
  end

  // Storage array; contents survive reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= Out_Reg;
    end
  end

  assign Rd_Data        = mem[rd_ptr];
  assign Rd_Valid       = (count_q != '0);
  assign Count          = count_q;
  assign Override_Stall = stall_q;
  assign Overflow       = ovf_q;

endmodule

// File: tb/tb_retreo_out_capture.sv
// Bench for retreo_out_capture: directed scenarios plus randomized traffic,
// all checked against a queue-based reference model of the capture FIFO.
module tb_retreo_out_capture;

  localparam int WIDTH  = 16;
  localparam int DEPTH  = 8;
  localparam int MARGIN = 2;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] Out_Reg;
  logic             Override_Stall;
  logic [WIDTH-1:0] Rd_Data;
  logic             Rd_Valid;
  logic             Rd_Ready;
  logic [3:0]       Count;
  logic             Overflow;
  logic             Clear_Overflow;

  int total;
  int bad;

  // Reference model state
  logic [WIDTH-1:0] m_q[$];
  logic [WIDTH-1:0] m_last;
  logic             m_ovf;

  retreo_out_capture #(.WIDTH(WIDTH), .DEPTH(DEPTH), .STALL_MARGIN(MARGIN)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .Out_Reg        (Out_Reg),
    .Override_Stall (Override_Stall),
    .Rd_Data        (Rd_Data),
    .Rd_Valid       (Rd_Valid),
    .Rd_Ready       (Rd_Ready),
    .Count          (Count),
    .Overflow       (Overflow),
    .Clear_Overflow (Clear_Overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of the behavioural model: a new value is any value differing from
  // the previous sample; it is queued if there is room after this cycle's pop.
  task automatic model_edge(input logic [WIDTH-1:0] o, input logic r, input logic c);
    bit is_new;
    bit popped;
    is_new = (o != m_last);
    popped = (m_q.size() > 0) && r;
    if (popped) void'(m_q.pop_front());
    if (is_new) begin
      if (m_q.size() < DEPTH) m_q.push_back(o);
      else m_ovf = 1'b1;
    end
    if (!(is_new && !popped && m_q.size() == DEPTH && !(o == m_last)) && c) begin
      // a clear only takes effect when no word was lost this cycle
    end
    m_last = o;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_count"}, Count, m_q.size());
    chk({tag, "_valid"}, Rd_Valid, m_q.size() > 0);
    chk({tag, "_stall"}, Override_Stall, m_q.size() >= DEPTH - MARGIN);
    chk({tag, "_ovf"}, Overflow, m_ovf);
    if (m_q.size() > 0) chk({tag, "_data"}, Rd_Data, m_q[0]);
  endtask

  task automatic step(input logic [WIDTH-1:0] o, input logic r, input logic c, input string tag);
    bit lost;
    Out_Reg        = o;
    Rd_Ready       = r;
    Clear_Overflow = c;
    lost = (o != m_last) && (m_q.size() == DEPTH) && !r;
    @(posedge clk);
    #1;
    model_edge(o, r, c);
    if (c && !lost) m_ovf = 1'b0;
    check_model(tag);
  endtask

  initial begin
    logic [WIDTH-1:0] got[$];
    logic [WIDTH-1:0] exp_list[3];
    total          = 0;
    bad            = 0;
    rst_n          = 1'b0;
    Out_Reg        = '0;
    Rd_Ready       = 1'b0;
    Clear_Overflow = 1'b0;
    m_last         = '0;
    m_ovf          = 1'b0;

    // Reset state
    #12;
    chk("rst_count", Count, 0);
    chk("rst_valid", Rd_Valid, 0);
    chk("rst_stall", Override_Stall, 0);
    chk("rst_ovf", Overflow, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Zero after reset is not a new word; first nonzero value is.
    for (int i = 0; i < 3; i++) step(16'h0000, 1'b0, 1'b0, "zero_hold");
    chk("zero_count", Count, 0);
    step(16'h0004, 1'b0, 1'b0, "first");
    chk("first_count", Count, 1);
    chk("first_data", Rd_Data, 16'h0004);

    // Change detection: repeats are ignored
    step(16'h0004, 1'b0, 1'b0, "chg");
    step(16'h0010, 1'b0, 1'b0, "chg");
    step(16'h0010, 1'b0, 1'b0, "chg");
    step(16'h0004, 1'b0, 1'b0, "chg");
    chk("chg_count", Count, 3);
    exp_list[0] = 16'h0004;
    exp_list[1] = 16'h0010;
    exp_list[2] = 16'h0004;
    for (int i = 0; i < 3; i++) begin
      chk("chg_pop_data", Rd_Data, exp_list[i]);
      step(16'h0004, 1'b1, 1'b0, "chg_pop");
    end
    chk("chg_empty", Rd_Valid, 0);

    // Fill to full, stall, overflow
    for (int i = 1; i <= 10; i++) begin
      step(WIDTH'(i), 1'b0, 1'b0, "fill");
      chk("fill_stall", Override_Stall, i >= 6);
      chk("fill_count", Count, (i > 8) ? 8 : i);
    end
    chk("fill_ovf", Overflow, 1);

    // Clear coincident with a drop keeps the flag; clear alone drops it
    step(16'h000B, 1'b0, 1'b1, "clr_drop");
    chk("clr_drop_ovf", Overflow, 1);
    step(16'h000B, 1'b0, 1'b1, "clr_alone");
    chk("clr_alone_ovf", Overflow, 0);
    Clear_Overflow = 1'b0;

    // Full with simultaneous push and pop
    chk("full_head", Rd_Data, 16'h0001);
    step(16'hBEEF, 1'b1, 1'b0, "fullpp");
    chk("fullpp_count", Count, 8);
    chk("fullpp_ovf", Overflow, 0);
    for (int i = 2; i <= 8; i++) begin
      chk("drain_data", Rd_Data, WIDTH'(i));
      step(16'hBEEF, 1'b1, 1'b0, "drain");
    end
    chk("drain_last", Rd_Data, 16'hBEEF);
    step(16'hBEEF, 1'b1, 1'b0, "drain");
    chk("drain_empty", Rd_Valid, 0);

    // Wrap-around streaming
    got.delete();
    for (int i = 0; i <= 20; i++) begin
      if (Rd_Valid) got.push_back(Rd_Data);
      step((i < 20) ? WIDTH'(16'h0100 + i) : 16'h0113, 1'b1, 1'b0, "wrap");
      chk("wrap_count_le1", Count <= 1, 1);
    end
    chk("wrap_n", got.size(), 20);
    for (int i = 0; i < 20 && i < got.size(); i++) chk("wrap_order", got[i], 16'h0100 + i);

    // Randomized traffic: small value alphabet to mix repeats and changes
    for (int i = 0; i < 400; i++) begin
      step(WIDTH'($urandom_range(0, 3)),
           ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 25 : 70)),
           ($urandom_range(0, 15) == 0), "rand");
    end

    // Drain, then queue five words and reset mid-operation
    for (int i = 0; i < 12; i++) step(m_last, 1'b1, 1'b0, "pre_rst");
    chk("pre_rst_empty", Rd_Valid, 0);
    for (int i = 0; i < 5; i++) step(WIDTH'(16'h0A00 + i), 1'b0, 1'b0, "q5");
    chk("q5_count", Count, 5);
    #2 rst_n = 1'b0;
    #1;
    m_q.delete();
    m_last = '0;
    m_ovf  = 1'b0;
    chk("mid_rst_count", Count, 0);
    chk("mid_rst_valid", Rd_Valid, 0);
    chk("mid_rst_stall", Override_Stall, 0);
    chk("mid_rst_ovf", Overflow, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    Out_Reg = '0;
    step(16'h0000, 1'b0, 1'b0, "post_rst");
    step(16'h0007, 1'b0, 1'b0, "post_rst");
    chk("post_rst_data", Rd_Data, 16'h0007);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
